// File: rtl/search_scan_ctrl.sv
// Sequencer for one full-search block-matching pass: loads the current block, streams the
// search window row by row, drains the SAD pipe and tags each valid SAD with its motion vector.
module search_scan_ctrl #(
    parameter int unsigned BLOCK_N    = 16,
    parameter int unsigned SEARCH_P   = 8,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned MV_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            turnenable,
    output logic            busy,
    output logic            done,
    output logic [3:0]      ctr_word,
    output logic            mem_en_input,
    output logic            mem_init_mode,
    output logic            cand_valid,
    output logic [MV_W-1:0] mv_x,
    output logic [MV_W-1:0] mv_y
);

    localparam int unsigned RowLen = BLOCK_N + 2 * SEARCH_P - 1;
    // Column counter also drives ctr_word[3:0], so it is never narrower than 4 bits.
    localparam int unsigned ColW = ($clog2(RowLen) > 4) ? $clog2(RowLen) : 4;
    localparam int unsigned VyW  = ($clog2(2 * SEARCH_P) > 1) ? $clog2(2 * SEARCH_P) : 1;
    localparam int unsigned FlW  = ($clog2(PIPE_DEPTH) > 1) ? $clog2(PIPE_DEPTH) : 1;

    localparam logic [ColW-1:0] IcntLast  = ColW'(BLOCK_N - 1);
    localparam logic [ColW-1:0] ColLast   = ColW'(RowLen - 1);
    localparam logic [ColW-1:0] ColCand0  = ColW'(BLOCK_N - 1);
    localparam logic [VyW-1:0]  VyLast    = VyW'(2 * SEARCH_P - 1);
    localparam logic [FlW-1:0]  FlushLast = FlW'(PIPE_DEPTH - 1);

    typedef enum logic [2:0] {StIdle, StInit, StScan, StFlush, StDone} state_e;

    state_e          state_q, state_d;
    logic [ColW-1:0] icnt_q, icnt_d;
    logic [ColW-1:0] col_q, col_d;
    logic [VyW-1:0]  vy_q, vy_d;
    logic [FlW-1:0]  fcnt_q, fcnt_d;

    logic            advance;
    logic            busy_d, done_d, en_d, init_d, cand_d;
    logic [3:0]      ctr_d;
    logic [MV_W-1:0] mvx_d, mvy_d;

    // IDLE always listens for start; every other state freezes while turnenable is low.
    assign advance = (state_q == StIdle) || turnenable;

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        col_d   = col_q;
        vy_d    = vy_q;
        fcnt_d  = fcnt_q;
        if (advance) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StInit;
                        icnt_d  = '0;
                    end
                end
                StInit: begin
                    if (icnt_q == IcntLast) begin
                        state_d = StScan;
                        icnt_d  = '0;
                        col_d   = '0;
                        vy_d    = '0;
                    end else begin
                        icnt_d = icnt_q + ColW'(1);
                    end
                end
                StScan: begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (vy_q == VyLast) begin
                            state_d = StFlush;
                            vy_d    = '0;
                            fcnt_d  = '0;
                        end else begin
                            vy_d = vy_q + VyW'(1);
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
                StFlush: begin
                    if (fcnt_q == FlushLast) begin
                        state_d = StDone;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FlW'(1);
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are computed from the next state so they line up with the state register.
    always_comb begin
        busy_d = busy;
        init_d = mem_init_mode;
        ctr_d  = ctr_word;
        en_d   = 1'b0;
        cand_d = 1'b0;
        done_d = 1'b0;
        mvx_d  = mv_x;
        mvy_d  = mv_y;
        if (advance) begin
            busy_d = (state_d != StIdle);
            init_d = (state_d == StInit);
            done_d = (state_d == StDone);
            ctr_d  = 4'd0;
            case (state_d)
                StInit: begin
                    en_d  = 1'b1;
                    ctr_d = icnt_d[3:0];
                end
                StScan: begin
                    en_d  = 1'b1;
                    ctr_d = col_d[3:0];
                    if (col_d >= ColCand0) begin
                        cand_d = 1'b1;
                        mvx_d  = MV_W'(int'(col_d) - int'(BLOCK_N) + 1 - int'(SEARCH_P));
                        mvy_d  = MV_W'(int'(vy_d) - int'(SEARCH_P));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            icnt_q        <= '0;
            col_q         <= '0;
            vy_q          <= '0;
            fcnt_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ctr_word      <= 4'd0;
            mem_en_input  <= 1'b0;
            mem_init_mode <= 1'b0;
            cand_valid    <= 1'b0;
            mv_x          <= '0;
            mv_y          <= '0;
        end else begin
            state_q       <= state_d;
            icnt_q        <= icnt_d;
            col_q         <= col_d;
            vy_q          <= vy_d;
            fcnt_q        <= fcnt_d;
            busy          <= busy_d;
            done          <= done_d;
            ctr_word      <= ctr_d;
            mem_en_input  <= en_d;
            mem_init_mode <= init_d;
            cand_valid    <= cand_d;
            mv_x          <= mvx_d;
            mv_y          <= mvy_d;
        end
    end

endmodule

// File: tb/tb_search_scan_ctrl.sv
// Directed bench for search_scan_ctrl: a default-size instance and a small
// (BLOCK_N=4, SEARCH_P=2, PIPE_DEPTH=1) instance sharing clock and inputs.
module tb_search_scan_ctrl;

    logic clk;
    logic rst, start, turnenable;
    logic sel;

    logic       busy_b, done_b, en_b, init_b, cand_b;
    logic [3:0] ctr_b;
    logic [4:0] mvx_b, mvy_b;
    logic       busy_s, done_s, en_s, init_s, cand_s;
    logic [3:0] ctr_s;
    logic [4:0] mvx_s, mvy_s;

    logic        m_busy, m_done, m_en, m_init, m_cand;
    logic [3:0]  m_ctr;
    logic [4:0]  m_mvx, m_mvy;
    logic [18:0] m_all;

    int n_assert, n_fail;
    int w_ncand, w_ninit, w_init_bad, w_stall_bad, w_done_cyc;
    logic [9:0] w_first, w_16, w_last, w_post;

    search_scan_ctrl dut_big (
        .clk(clk), .rst(rst), .start(start), .turnenable(turnenable),
        .busy(busy_b), .done(done_b), .ctr_word(ctr_b), .mem_en_input(en_b),
        .mem_init_mode(init_b), .cand_valid(cand_b), .mv_x(mvx_b), .mv_y(mvy_b)
    );

    search_scan_ctrl #(.BLOCK_N(4), .SEARCH_P(2), .PIPE_DEPTH(1), .MV_W(5)) dut_small (
        .clk(clk), .rst(rst), .start(start), .turnenable(turnenable),
        .busy(busy_s), .done(done_s), .ctr_word(ctr_s), .mem_en_input(en_s),
        .mem_init_mode(init_s), .cand_valid(cand_s), .mv_x(mvx_s), .mv_y(mvy_s)
    );

    assign m_busy = sel ? busy_s : busy_b;
    assign m_done = sel ? done_s : done_b;
    assign m_en   = sel ? en_s   : en_b;
    assign m_init = sel ? init_s : init_b;
    assign m_cand = sel ? cand_s : cand_b;
    assign m_ctr  = sel ? ctr_s  : ctr_b;
    assign m_mvx  = sel ? mvx_s  : mvx_b;
    assign m_mvy  = sel ? mvy_s  : mvy_b;
    assign m_all  = {m_busy, m_done, m_ctr, m_en, m_init, m_cand, m_mvx, m_mvy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mvpair(input int x, input int y);
        logic [4:0] xs, ys;
        xs = x[4:0];
        ys = y[4:0];
        return {xs, ys};
    endfunction

    task automatic start_pass();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Follows one pass from the first cycle after start; returns at the done sample,
    // or at candidate stop_at. Candidates are checked against a raster-order model.
    task automatic watch(input int stall_after, input int stall_len, input int poke_cyc,
                         input int stop_at);
        int cyc, ex, ey, pp, sleft;
        bit want_post;
        logic [9:0] cur;
        pp = sel ? 2 : 8;
        ex = -pp;
        ey = -pp;
        cyc = 0;
        sleft = 0;
        want_post = 1'b0;
        w_ncand = 0; w_ninit = 0; w_init_bad = 0; w_stall_bad = 0; w_done_cyc = 0;
        w_first = '0; w_16 = '0; w_last = '0; w_post = '0;
        while (cyc < 3000) begin
            cyc++;
            if (cyc == poke_cyc) start = 1'b1;
            else if (cyc == poke_cyc + 1) start = 1'b0;
            if (sleft > 0) begin
                if (m_en || m_cand || m_done) w_stall_bad++;
                sleft--;
                if (sleft == 0) turnenable = 1'b1;
            end else begin
                if (m_init) begin
                    if (m_ctr != w_ninit[3:0]) w_init_bad++;
                    w_ninit++;
                end
                if (m_cand) begin
                    cur = {m_mvx, m_mvy};
                    w_ncand++;
                    chk("cand_order", 32'(cur), 32'(mvpair(ex, ey)));
                    if (w_ncand == 1) w_first = cur;
                    if (w_ncand == 16) w_16 = cur;
                    w_last = cur;
                    if (want_post) begin
                        w_post = cur;
                        want_post = 1'b0;
                    end
                    ex++;
                    if (ex == pp) begin
                        ex = -pp;
                        ey++;
                    end
                    if (w_ncand == stall_after) begin
                        turnenable = 1'b0;
                        sleft = stall_len;
                        want_post = 1'b1;
                    end
                    if (stop_at > 0 && w_ncand == stop_at) break;
                end
                if (m_done) begin
                    w_done_cyc = cyc;
                    break;
                end
            end
            step();
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        sel = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        turnenable = 1'b1;

        // Reset and idle
        repeat (3) step();
        chk("reset_outputs", 32'(m_all), 32'd0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_no_start", 32'(m_all), 32'd0);

        // Full default pass
        start_pass();
        watch(0, 0, 0, 0);
        chk("init_cycles", 32'(w_ninit), 32'd16);
        chk("init_ctr_seq", 32'(w_init_bad), 32'd0);
        chk("cand_count", 32'(w_ncand), 32'd256);
        chk("cand_first", 32'(w_first), 32'(mvpair(-8, -8)));
        chk("cand_16th", 32'(w_16), 32'(mvpair(7, -8)));
        chk("cand_last", 32'(w_last), 32'(mvpair(7, 7)));
        chk("done_cycle", 32'(w_done_cyc), 32'd517);
        step();
        chk("idle_after_done", 32'({m_busy, m_done}), 32'd0);

        // 5-cycle stall right after candidate (3,-2)
        start_pass();
        watch(108, 5, 0, 0);
        chk("stall_cand_count", 32'(w_ncand), 32'd256);
        chk("stall_quiet", 32'(w_stall_bad), 32'd0);
        chk("stall_resume_mv", 32'(w_post), 32'(mvpair(4, -2)));
        chk("stall_done_cycle", 32'(w_done_cyc), 32'd522);
        step();

        // start pulses in SCAN and in DONE are ignored
        start_pass();
        watch(0, 0, 200, 0);
        chk("poke_cand_count", 32'(w_ncand), 32'd256);
        chk("poke_done_cycle", 32'(w_done_cyc), 32'd517);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_done_ignored", 32'(m_busy), 32'd0);
        repeat (3) step();
        chk("no_extra_pass", 32'({m_busy, m_done}), 32'd0);

        // Reset at candidate 100 aborts, then a clean pass
        start_pass();
        watch(0, 0, 0, 100);
        chk("abort_at_cand", 32'(w_ncand), 32'd100);
        rst = 1'b1;
        start = 1'b1;
        step();
        chk("abort_outputs", 32'(m_all), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        repeat (2) step();
        chk("abort_no_done", 32'({m_busy, m_done}), 32'd0);
        start_pass();
        watch(0, 0, 0, 0);
        chk("post_abort_count", 32'(w_ncand), 32'd256);
        chk("post_abort_first", 32'(w_first), 32'(mvpair(-8, -8)));
        chk("post_abort_done", 32'(w_done_cyc), 32'd517);
        step();

        // Small configuration, with start held through DONE
        sel = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        start_pass();
        watch(0, 0, 0, 0);
        chk("small_init_cycles", 32'(w_ninit), 32'd4);
        chk("small_init_ctr", 32'(w_init_bad), 32'd0);
        chk("small_cand_count", 32'(w_ncand), 32'd16);
        chk("small_first", 32'(w_first), 32'(mvpair(-2, -2)));
        chk("small_last", 32'(w_last), 32'(mvpair(1, 1)));
        chk("small_done_cycle", 32'(w_done_cyc), 32'd34);
        start = 1'b1;
        step();
        chk("held_start_idle_gap", 32'(m_busy), 32'd0);
        step();
        chk("held_start_restart", 32'({m_busy, m_init}), 32'd3);
        start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
